// File: rtl/btn_evt_dec_pkg.sv
// Shared state encoding and default timing constants for the button event decoder.
`timescale 1ns/1ps
package btn_evt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_LONG   = 3'd2,
        ST_WAIT2  = 3'd3,
        ST_PRESS2 = 3'd4
    } state_t;

    localparam int DEF_LONG_PRESS_COUNT = 20;
    localparam int DEF_DBL_GAP_COUNT    = 12;
    localparam int DEF_CNT_W            = 16;

endpackage

// File: rtl/btn_evt_dec_edge_det.sv
// Registers the debounced level once and flags its rising and falling edges.
`timescale 1ns/1ps
module edge_det (
    input  logic clk,
    input  logic reset_b,
    input  logic fil_sig,
    output logic rise,
    output logic fall
);

    logic sig_q_reg;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sig_q_reg <= 1'b0;
        end else begin
            sig_q_reg <= fil_sig;
        end
    end

    // A level already high when reset is released is seen as a fresh press.
    assign rise = fil_sig & ~sig_q_reg;
    assign fall = ~fil_sig & sig_q_reg;

endmodule

// File: rtl/btn_evt_dec.sv
// Classifies a debounced button level into one-cycle press/release/short/long/double events.
`timescale 1ns/1ps
module btn_evt_dec
    import btn_evt_pkg::*;
#(
    parameter int LONG_PRESS_COUNT = DEF_LONG_PRESS_COUNT,
    parameter int DBL_GAP_COUNT    = DEF_DBL_GAP_COUNT,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset_b,
    input  logic fil_sig,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_evt,
    output logic long_evt,
    output logic double_evt,
    output logic held,
    output logic busy
);

    generate
        if (LONG_PRESS_COUNT < 2 || LONG_PRESS_COUNT > (2 ** CNT_W) - 1) begin : g_bad_long
            $error("btn_evt_dec: LONG_PRESS_COUNT out of range");
        end
        if (DBL_GAP_COUNT < 2 || DBL_GAP_COUNT > (2 ** CNT_W) - 1) begin : g_bad_gap
            $error("btn_evt_dec: DBL_GAP_COUNT out of range");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LONG_M1  = CNT_W'(LONG_PRESS_COUNT - 1);
    localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_PRESS_COUNT);
    localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(DBL_GAP_COUNT);

    logic rise;
    logic fall;

    edge_det u_edge_det (
        .clk     (clk),
        .reset_b (reset_b),
        .fil_sig (fil_sig),
        .rise    (rise),
        .fall    (fall)
    );

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic             short_next, long_next, double_next;

    logic press_reg, release_reg, short_reg, long_reg, double_reg, held_reg, busy_reg;

    assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_inc;
        short_next  = 1'b0;
        long_next   = 1'b0;
        double_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (rise) begin
                    state_next = ST_PRESS1;
                    cnt_next   = CNT_ONE;
                end
            end
            ST_PRESS1: begin
                if (fall) begin
                    state_next = ST_WAIT2;
                    cnt_next   = CNT_ONE;
                end else if (fil_sig && cnt_reg == LONG_M1) begin
                    state_next = ST_LONG;
                    long_next  = 1'b1;
                end
            end
            ST_LONG: begin
                if (fall) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT2: begin
                // A rise landing on the timeout cycle starts a new first click.
                if (cnt_reg >= GAP_CNT) begin
                    short_next = 1'b1;
                    if (rise) begin
                        state_next = ST_PRESS1;
                        cnt_next   = CNT_ONE;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (rise) begin
                    state_next = ST_PRESS2;
                    cnt_next   = CNT_ONE;
                end
            end
            ST_PRESS2: begin
                if (fall) begin
                    state_next  = ST_IDLE;
                    double_next = 1'b1;
                end else if (fil_sig && cnt_reg == LONG_CNT) begin
                    state_next = ST_LONG;
                    short_next = 1'b1;
                    long_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            short_reg   <= 1'b0;
            long_reg    <= 1'b0;
            double_reg  <= 1'b0;
            held_reg    <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            press_reg   <= rise;
            release_reg <= fall;
            short_reg   <= short_next;
            long_reg    <= long_next;
            double_reg  <= double_next;
            held_reg    <= (state_next == ST_LONG);
            busy_reg    <= (state_next != ST_IDLE);
        end
    end

    assign press_pulse   = press_reg;
    assign release_pulse = release_reg;
    assign short_evt     = short_reg;
    assign long_evt      = long_reg;
    assign double_evt    = double_reg;
    assign held          = held_reg;
    assign busy          = busy_reg;

endmodule
